// File: rtl/logicgates_bist_checker.sv
// Built-in self-test engine for the two-input gate block (AND, OR, NAND, NOR,
// XOR, XNOR, NOT a). Walks {a,b} through 00, 01, 10, 11, lets each vector
// settle, samples the seven gate outputs and accumulates per-vector and
// per-gate failure flags plus a saturating mismatch count.
//
// Handshake: start is level-sampled and accepted only in IDLE or DONE;
// busy is high from the accept edge until the last vector is checked, and
// done then stays high (with results frozen) until the next accepted start
// or reset.
module logicgates_bist_checker #(
  parameter int SETTLE_CYCLES = 1,
  parameter int ERR_W         = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             and_y,
  input  logic             or_y,
  input  logic             nand_y,
  input  logic             nor_y,
  input  logic             xor_y,
  input  logic             xnor_y,
  input  logic             not_y,
  output logic             a_out,
  output logic             b_out,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [3:0]       fail_vec,
  output logic [6:0]       fail_gate,
  output logic [ERR_W-1:0] err_count,
  output logic [1:0]       state_dbg
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETTLE = 2'd1;
  localparam logic [1:0] ST_CHECK  = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;

  localparam logic [7:0] CNT_LOAD = 8'(SETTLE_CYCLES);
  // Sum is kept wide enough that adding up to 7 never wraps before saturation.
  localparam int SUM_W = ERR_W + 4;
  localparam logic [SUM_W-1:0] ERR_MAX = {4'b0000, {ERR_W{1'b1}}};

  logic [1:0]       state;
  logic [1:0]       vec;
  logic [7:0]       cnt;
  logic [6:0]       expected;
  logic [6:0]       observed;
  logic [6:0]       mism;
  logic [2:0]       mism_cnt;
  logic [SUM_W-1:0] err_sum;
  logic [ERR_W-1:0] err_next;

  assign state_dbg = state;

  // Result is only meaningful once the run has finished; never high while busy.
  assign pass = done & (err_count == '0);

  // Golden gate outputs from the registered stimulus, and the mismatch vector.
  always_comb begin
    expected = {~a_out, ~(a_out ^ b_out), a_out ^ b_out, ~(a_out | b_out),
                ~(a_out & b_out), a_out | b_out, a_out & b_out};
    observed = {not_y, xnor_y, xor_y, nor_y, nand_y, or_y, and_y};
    mism     = expected ^ observed;
  end

  // Population count of mismatching gate bits and the saturating error total.
  always_comb begin
    mism_cnt = 3'd0;
    for (int i = 0; i < 7; i++) begin
      mism_cnt = mism_cnt + {2'b00, mism[i]};
    end
    err_sum  = {4'b0000, err_count} + {{(SUM_W-3){1'b0}}, mism_cnt};
    err_next = (err_sum > ERR_MAX) ? {ERR_W{1'b1}} : err_sum[ERR_W-1:0];
  end

  // Test sequencer: accept start, step vectors, settle, check, report.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      vec       <= 2'd0;
      cnt       <= 8'd0;
      a_out     <= 1'b0;
      b_out     <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      fail_vec  <= 4'd0;
      fail_gate <= 7'd0;
      err_count <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            fail_vec  <= 4'd0;
            fail_gate <= 7'd0;
            err_count <= '0;
            vec       <= 2'd0;
            a_out     <= 1'b0;
            b_out     <= 1'b0;
            cnt       <= CNT_LOAD;
            busy      <= 1'b1;
            done      <= 1'b0;
            state     <= ST_SETTLE;
          end
        end
        ST_SETTLE: begin
          cnt <= cnt - 8'd1;
          if (cnt == 8'd1) state <= ST_CHECK;
        end
        ST_CHECK: begin
          fail_gate <= fail_gate | mism;
          if (|mism) fail_vec[vec] <= 1'b1;
          err_count <= err_next;
          if (vec != 2'd3) begin
            vec            <= vec + 2'd1;
            {a_out, b_out} <= vec + 2'd1;
            cnt            <= CNT_LOAD;
            state          <= ST_SETTLE;
          end else begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= ST_DONE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_logicgates_bist_checker.sv
// Directed bench for logicgates_bist_checker: a behavioural gate block with
// selectable faults sits beside each checker instance (SETTLE_CYCLES=1 and 3).
module tb_logicgates_bist_checker;

  logic clk;
  logic rst_n;

  int n_cmp;
  int n_bad;

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- instance 1: default settle ----------------
  logic       start1;
  logic [1:0] mode1;   // 0 good, 1 xor stuck 0, 2 not_y = a, 3 and/or swapped
  logic       a1, b1, busy1, done1, pass1;
  logic [3:0] fv1;
  logic [6:0] fg1;
  logic [4:0] ec1;
  logic [1:0] st1;
  logic       and1, or1, nand1, nor1, xor1, xnor1, not1;

  // Faultable gate block for instance 1.
  always_comb begin
    and1  = (mode1 == 2'd3) ? (a1 | b1) : (a1 & b1);
    or1   = (mode1 == 2'd3) ? (a1 & b1) : (a1 | b1);
    nand1 = ~(a1 & b1);
    nor1  = ~(a1 | b1);
    xor1  = (mode1 == 2'd1) ? 1'b0 : (a1 ^ b1);
    xnor1 = ~(a1 ^ b1);
    not1  = (mode1 == 2'd2) ? a1 : ~a1;
  end

  logicgates_bist_checker #(.SETTLE_CYCLES(1), .ERR_W(5)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1),
    .and_y(and1), .or_y(or1), .nand_y(nand1), .nor_y(nor1),
    .xor_y(xor1), .xnor_y(xnor1), .not_y(not1),
    .a_out(a1), .b_out(b1), .busy(busy1), .done(done1), .pass(pass1),
    .fail_vec(fv1), .fail_gate(fg1), .err_count(ec1), .state_dbg(st1)
  );

  // ---------------- instance 2: SETTLE_CYCLES=3 ----------------
  logic       start2;
  logic [1:0] mode2;
  logic       a2, b2, busy2, done2, pass2;
  logic [3:0] fv2;
  logic [6:0] fg2;
  logic [4:0] ec2;
  logic [1:0] st2;
  logic       and2, or2, nand2, nor2, xor2, xnor2, not2;

  // Faultable gate block for instance 2.
  always_comb begin
    and2  = (mode2 == 2'd3) ? (a2 | b2) : (a2 & b2);
    or2   = (mode2 == 2'd3) ? (a2 & b2) : (a2 | b2);
    nand2 = ~(a2 & b2);
    nor2  = ~(a2 | b2);
    xor2  = (mode2 == 2'd1) ? 1'b0 : (a2 ^ b2);
    xnor2 = ~(a2 ^ b2);
    not2  = (mode2 == 2'd2) ? a2 : ~a2;
  end

  logicgates_bist_checker #(.SETTLE_CYCLES(3), .ERR_W(5)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2),
    .and_y(and2), .or_y(or2), .nand_y(nand2), .nor_y(nor2),
    .xor_y(xor2), .xnor_y(xnor2), .not_y(not2),
    .a_out(a2), .b_out(b2), .busy(busy2), .done(done2), .pass(pass2),
    .fail_vec(fv2), .fail_gate(fg2), .err_count(ec2), .state_dbg(st2)
  );

  // Per-edge trace of instance 1 captured by the driver, index = edges after accept.
  logic [1:0] ab_tr [0:63];
  logic       bz_tr [0:63];

  // ---------------- driver tasks ----------------
  // Pulse start1 for one edge and follow the run until done1 or the budget expires.
  task automatic run1(output int edges);
    @(negedge clk);
    start1 = 1'b1;
    @(posedge clk);
    #1;
    start1   = 1'b0;
    edges    = 0;
    ab_tr[0] = {a1, b1};
    bz_tr[0] = busy1;
    while (!done1 && edges < 100) begin
      @(posedge clk);
      #1;
      edges++;
      if (edges < 64) begin
        ab_tr[edges] = {a1, b1};
        bz_tr[edges] = busy1;
      end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n  = 1'b0;
    start1 = 1'b0;
    start2 = 1'b0;
    mode1  = 2'd0;
    mode2  = 2'd0;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if ({a1, b1, busy1, done1, pass1, fv1, fg1, ec1, st1} !== 25'd0) begin
      n_bad++;
      $display("FAIL reset_dut1: got a=%b b=%b busy=%b done=%b pass=%b fv=%b fg=%b ec=%0d st=%0d, want all 0",
               a1, b1, busy1, done1, pass1, fv1, fg1, ec1, st1);
    end
    n_cmp++;
    if ({a2, b2, busy2, done2, pass2, fv2, fg2, ec2, st2} !== 25'd0) begin
      n_bad++;
      $display("FAIL reset_dut2: got a=%b b=%b busy=%b done=%b pass=%b fv=%b fg=%b ec=%0d st=%0d, want all 0",
               a2, b2, busy2, done2, pass2, fv2, fg2, ec2, st2);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (busy1 !== 1'b0 || done1 !== 1'b0) begin
      n_bad++;
      $display("FAIL idle_hold: got busy=%b done=%b, want 0 0", busy1, done1);
    end
  endtask

  task automatic test_good_pass();
    int edges;
    mode1 = 2'd0;
    run1(edges);
    n_cmp++;
    if (edges !== 8) begin
      n_bad++;
      $display("FAIL good_latency: got %0d edges, want 8", edges);
    end
    for (int k = 0; k < 8; k++) begin
      n_cmp++;
      if (bz_tr[k] !== 1'b1 || ab_tr[k] !== 2'(k / 2)) begin
        n_bad++;
        $display("FAIL good_trace[%0d]: got busy=%b ab=%b, want busy=1 ab=%b", k, bz_tr[k], ab_tr[k], 2'(k / 2));
      end
    end
    n_cmp++;
    if ({busy1, done1, pass1, ec1, fv1, fg1, a1, b1, st1} !== {3'b011, 5'd0, 4'd0, 7'd0, 2'b11, 2'd3}) begin
      n_bad++;
      $display("FAIL good_result: got busy=%b done=%b pass=%b ec=%0d fv=%b fg=%b ab=%b%b st=%0d, want 0 1 1 0 0000 0000000 11 3",
               busy1, done1, pass1, ec1, fv1, fg1, a1, b1, st1);
    end
    // Results hold in DONE, and the *_y inputs are ignored there.
    mode1 = 2'd2;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if ({done1, pass1, ec1, fv1, fg1} !== {2'b11, 5'd0, 4'd0, 7'd0}) begin
      n_bad++;
      $display("FAIL done_hold: got done=%b pass=%b ec=%0d fv=%b fg=%b, want 1 1 0 0000 0000000",
               done1, pass1, ec1, fv1, fg1);
    end
  endtask

  task automatic test_xor_stuck();
    int edges;
    mode1 = 2'd1;
    run1(edges);
    n_cmp++;
    if (edges !== 8 || {done1, pass1, ec1, fv1, fg1} !== {2'b10, 5'd2, 4'b0110, 7'b0010000}) begin
      n_bad++;
      $display("FAIL xor_stuck: got edges=%0d done=%b pass=%b ec=%0d fv=%b fg=%b, want 8 1 0 2 0110 0010000",
               edges, done1, pass1, ec1, fv1, fg1);
    end
  endtask

  task automatic test_not_inverted();
    int edges;
    mode1 = 2'd2;
    run1(edges);
    n_cmp++;
    if (edges !== 8 || {done1, pass1, ec1, fv1, fg1} !== {2'b10, 5'd4, 4'b1111, 7'b1000000}) begin
      n_bad++;
      $display("FAIL not_inverted: got edges=%0d done=%b pass=%b ec=%0d fv=%b fg=%b, want 8 1 0 4 1111 1000000",
               edges, done1, pass1, ec1, fv1, fg1);
    end
  endtask

  task automatic test_and_or_swap();
    int edges;
    mode1 = 2'd3;
    run1(edges);
    n_cmp++;
    if (edges !== 8 || {done1, pass1, ec1, fv1, fg1} !== {2'b10, 5'd4, 4'b0110, 7'b0000011}) begin
      n_bad++;
      $display("FAIL and_or_swap: got edges=%0d done=%b pass=%b ec=%0d fv=%b fg=%b, want 8 1 0 4 0110 0000011",
               edges, done1, pass1, ec1, fv1, fg1);
    end
  endtask

  task automatic test_midrun_start_reset();
    int edges;
    mode1 = 2'd0;
    @(negedge clk);
    start1 = 1'b1;
    @(posedge clk);
    #1;
    start1 = 1'b0;
    for (int e = 1; e <= 5; e++) begin
      @(posedge clk);
      #1;
      if (e == 2) start1 = 1'b1;
      if (e == 4) start1 = 1'b0;
    end
    n_cmp++;
    if (busy1 !== 1'b1 || done1 !== 1'b0 || {a1, b1} !== 2'b10) begin
      n_bad++;
      $display("FAIL midrun_ignore_start: got busy=%b done=%b ab=%b%b, want 1 0 10", busy1, done1, a1, b1);
    end
    // Reset between clock edges must clear everything without waiting for clk.
    #3;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({a1, b1, busy1, done1, pass1, fv1, fg1, ec1, st1} !== 25'd0) begin
      n_bad++;
      $display("FAIL async_reset: got a=%b b=%b busy=%b done=%b pass=%b fv=%b fg=%b ec=%0d st=%0d, want all 0",
               a1, b1, busy1, done1, pass1, fv1, fg1, ec1, st1);
    end
    @(negedge clk);
    rst_n = 1'b1;
    run1(edges);
    n_cmp++;
    if (edges !== 8 || {done1, pass1, ec1, fv1, fg1} !== {2'b11, 5'd0, 4'd0, 7'd0}) begin
      n_bad++;
      $display("FAIL post_reset_run: got edges=%0d done=%b pass=%b ec=%0d fv=%b fg=%b, want 8 1 1 0 0000 0000000",
               edges, done1, pass1, ec1, fv1, fg1);
    end
  endtask

  task automatic test_back_to_back();
    int edges;
    logic [1:0] ab_seen [0:3];
    // First a failing run on the slow instance.
    mode2 = 2'd1;
    @(negedge clk);
    start2 = 1'b1;
    @(posedge clk);
    #1;
    start2 = 1'b0;
    edges  = 0;
    while (!done2 && edges < 100) begin
      @(posedge clk);
      #1;
      edges++;
    end
    n_cmp++;
    if (edges !== 16 || {pass2, ec2, fv2, fg2} !== {1'b0, 5'd2, 4'b0110, 7'b0010000}) begin
      n_bad++;
      $display("FAIL slow_fail_run: got edges=%0d pass=%b ec=%0d fv=%b fg=%b, want 16 0 2 0110 0010000",
               edges, pass2, ec2, fv2, fg2);
    end
    // Restart straight from DONE: flags clear on the accept edge.
    mode2 = 2'd0;
    @(negedge clk);
    start2 = 1'b1;
    @(posedge clk);
    #1;
    start2 = 1'b0;
    n_cmp++;
    if ({busy2, done2, pass2, ec2, fv2, fg2, a2, b2} !== {3'b100, 5'd0, 4'd0, 7'd0, 2'b00}) begin
      n_bad++;
      $display("FAIL restart_clear: got busy=%b done=%b pass=%b ec=%0d fv=%b fg=%b ab=%b%b, want 1 0 0 0 0000 0000000 00",
               busy2, done2, pass2, ec2, fv2, fg2, a2, b2);
    end
    edges = 0;
    ab_seen[0] = {a2, b2};
    while (!done2 && edges < 100) begin
      @(posedge clk);
      #1;
      edges++;
      if (edges == 4)  ab_seen[1] = {a2, b2};
      if (edges == 8)  ab_seen[2] = {a2, b2};
      if (edges == 12) ab_seen[3] = {a2, b2};
    end
    for (int v = 0; v < 4; v++) begin
      n_cmp++;
      if (ab_seen[v] !== 2'(v)) begin
        n_bad++;
        $display("FAIL slow_step[%0d]: got ab=%b, want %b", v, ab_seen[v], 2'(v));
      end
    end
    n_cmp++;
    if (edges !== 16 || {busy2, done2, pass2, ec2, fv2, fg2} !== {3'b011, 5'd0, 4'd0, 7'd0}) begin
      n_bad++;
      $display("FAIL slow_pass_run: got edges=%0d busy=%b done=%b pass=%b ec=%0d fv=%b fg=%b, want 16 0 1 1 0 0000 0000000",
               edges, busy2, done2, pass2, ec2, fv2, fg2);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    n_cmp = 0;
    n_bad = 0;
    test_reset();
    test_good_pass();
    test_xor_stuck();
    test_not_inverted();
    test_and_or_swap();
    test_midrun_start_reset();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
